i2c_slave_regs: RTL

Synthesizable I2C slave with an 8-bit register bank: the downstream consumer of the SDA/SCL lines driven by the team's I2C master, replacing the behavioural slave model in silicon-facing configurations. It oversamples SCL/SDA on the I2C core clock, decodes START/STOP, matches a 7-bit address, and services register-pointer writes, data writes and auto-incrementing reads. A local read port and write strobe expose the bank to on-chip logic.

---
 rtl/i2c_slave_regs_if.sv | 26 ++
 rtl/i2c_slave_regs.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs_if.sv
// I2C line pins plus local register-bank read/write-notify signals for i2c_slave_regs.
interface i2c_slave_regs_if #(
   parameter int NREGS = 16
);
   localparam int AW = $clog2(NREGS);

   logic          scl_i;
   logic          sda_i;
   logic          sda_oe_o;
   logic [AW-1:0] loc_addr_i;
   logic [7:0]    loc_rdata_o;
   logic          wr_stb_o;
   logic [AW-1:0] wr_addr_o;
   logic [7:0]    wr_data_o;
   logic          busy_o;

   modport slave (
      input  scl_i, sda_i, loc_addr_i,
      output sda_oe_o, loc_rdata_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o
   );

   modport master (
      output scl_i, sda_i, loc_addr_i,
      input  sda_oe_o, loc_rdata_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o
   );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C slave with an auto-incrementing 8-bit register bank; SDA oversampled on the core clock.
// Pin-to-event latency 3 clocks, SDA drive changes HOLD_CYC clocks after a detected SCL fall.
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         NREGS      = 16,
   parameter int         HOLD_CYC   = 4
) (
   input logic             i2c_core_clk_i,
   input logic             i2c_core_rst_i,
   i2c_slave_regs_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
   } state_t;

   state_t        state;
   logic [2:0]    scl_sync;
   logic [2:0]    sda_sync;
   logic [7:0]    shift;
   logic [7:0]    shift_in;
   logic [3:0]    bit_cnt;
   logic [AW-1:0] ptr;
   logic          first_byte;
   logic [7:0]    hold_cnt;
   logic          drive;
   logic          scl_rise;
   logic          scl_fall;
   logic          start_det;
   logic          stop_det;
   logic [7:0]    regs [NREGS];

   // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
   always_ff @(posedge i2c_core_clk_i) begin
      if (i2c_core_rst_i) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], bus.scl_i};
         sda_sync <= {sda_sync[1:0], bus.sda_i};
      end
   end

   assign scl_rise  = scl_sync[1] & ~scl_sync[2];
   assign scl_fall  = ~scl_sync[1] & scl_sync[2];
   assign start_det = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
   assign stop_det  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];
   assign shift_in  = {shift[6:0], sda_sync[1]};

   assign bus.loc_rdata_o = regs[bus.loc_addr_i];

   // Level SDA should take once the hold delay after the latest SCL fall expires.
   always_comb begin
      drive = 1'b0;
      case (state)
         ADDR_ACK, WR_ACK: drive = 1'b1;
         RD_BYTE:          drive = ~shift[7];
         default:          drive = 1'b0;
      endcase
   end

   always_ff @(posedge i2c_core_clk_i) begin
      if (i2c_core_rst_i) begin
         state         <= IDLE;
         shift         <= 8'h00;
         bit_cnt       <= 4'd0;
         ptr           <= '0;
         first_byte    <= 1'b0;
         hold_cnt      <= 8'd0;
         bus.sda_oe_o  <= 1'b0;
         bus.wr_stb_o  <= 1'b0;
         bus.wr_addr_o <= '0;
         bus.wr_data_o <= 8'h00;
         bus.busy_o    <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
      end else begin
         bus.wr_stb_o <= 1'b0;
         if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_cnt == 8'd1) bus.sda_oe_o <= drive;
         end
         if (start_det) begin
            state        <= ADDR;
            bit_cnt      <= 4'd0;
            hold_cnt     <= 8'd0;
            bus.sda_oe_o <= 1'b0;
            bus.busy_o   <= 1'b1;
         end else if (stop_det) begin
            state        <= IDLE;
            hold_cnt     <= 8'd0;
            bus.sda_oe_o <= 1'b0;
            bus.busy_o   <= 1'b0;
         end else begin
            if (scl_fall) hold_cnt <= 8'(HOLD_CYC);
            // In the ACK states bit_cnt==1 marks that the 9th rise has been seen.
            case (state)
               ADDR: if (scl_rise) begin
                  shift <= shift_in;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     state   <= (shift_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               ADDR_ACK: if (scl_rise) begin
                  bit_cnt <= 4'd1;
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  bit_cnt <= 4'd0;
                  if (shift[0]) begin
                     shift <= regs[ptr];
                     state <= RD_BYTE;
                  end else begin
                     first_byte <= 1'b1;
                     state      <= WR_BYTE;
                  end
               end
               WR_BYTE: if (scl_rise) begin
                  shift <= shift_in;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     state   <= WR_ACK;
                     if (first_byte) begin
                        ptr        <= shift_in[AW-1:0];
                        first_byte <= 1'b0;
                     end else begin
                        regs[ptr]     <= shift_in;
                        bus.wr_stb_o  <= 1'b1;
                        bus.wr_addr_o <= ptr;
                        bus.wr_data_o <= shift_in;
                        ptr           <= ptr + AW'(1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               WR_ACK: if (scl_rise) begin
                  bit_cnt <= 4'd1;
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  bit_cnt <= 4'd0;
                  state   <= WR_BYTE;
               end
               RD_BYTE: if (scl_fall) begin
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     state   <= RD_ACK;
                     ptr     <= ptr + AW'(1);
                  end else begin
                     shift   <= {shift[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               RD_ACK: if (scl_rise) begin
                  if (sda_sync[1]) state <= IDLE;
                  else             bit_cnt <= 4'd1;
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  bit_cnt <= 4'd0;
                  shift   <= regs[ptr];
                  state   <= RD_BYTE;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
